// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bundle between a multicycle core (master) and the
//   memory responder (slave).
//   req     : access request, only looked at while the responder is idle
//   we      : 1 = store, 0 = load
//   addr    : byte address
//   wdata   : store data, right-aligned (byte in [7:0], half in [15:0])
//   funct3  : RV32I size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   ready   : one-cycle completion pulse
//   err     : one-cycle error flag, coincident with ready
//   rdata   : registered load result, valid while ready=1
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        ready;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, funct3,
        input  ready, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata, funct3,
        output ready, err, rdata
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Unified instruction/data memory of DEPTH_WORDS 32-bit words serving a
//   multicycle RV32I core. Each accepted request waits WAIT_CYCLES cycles,
//   performs one access cycle and then pulses ready for one cycle. Illegal
//   requests (bad funct3 for the direction, misaligned, out of range)
//   complete one cycle after acceptance with err=1 and rdata=0 and never
//   touch memory.
// Ports
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; aborts any request in flight
//   bus   : mem_responder_if slave modport (req/we/addr/wdata/funct3 in,
//           ready/err/rdata out)
// Parameters
//   DEPTH_WORDS : memory size in 32-bit words
//   WAIT_CYCLES : wait cycles inserted before each access (0 allowed)
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP,
        ERR
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            ready_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    // Request captured in IDLE; only the address bits that select a word and
    // a byte lane are kept, the upper bits are consumed by the range check.
    logic            we_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      funct3_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            legal;
    logic [AW-1:0]   word_idx;
    logic [1:0]      byte_off;
    logic [3:0]      wmask;
    logic [31:0]     wlane;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Legality of a request as presented on the bus.
    function automatic logic req_legal(input logic w, input logic [31:0] a,
                                       input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a[1:0] == 2'b00);
            3'b100:  ok = ~w;
            3'b101:  ok = ~w & ~a[0];
            default: ok = 1'b0;
        endcase
        if ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS))
            ok = 1'b0;
        return ok;
    endfunction

    // Byte-lane enables for a store, little-endian.
    function automatic logic [3:0] store_mask(input logic [1:0] off,
                                              input logic [2:0] f3);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Store data replicated across lanes so the mask alone picks placement.
    function automatic logic [31:0] store_data(input logic [31:0] wd,
                                               input logic [2:0] f3);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Lane select plus sign/zero extension of a load result.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] ext_s;
        logic        [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        b_s = b;
        h_s = h;
        ext_s = '0;
        case (f3)
            3'b000: begin
                ext_s = b_s;
                r = ext_s;
            end
            3'b001: begin
                ext_s = h_s;
                r = ext_s;
            end
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign accept   = (state == IDLE) && bus.req;
    assign legal    = req_legal(bus.we, bus.addr, bus.funct3);
    assign word_idx = addr_q[AW+1:2];
    assign byte_off = addr_q[1:0];
    assign wmask    = store_mask(byte_off, funct3_q);
    assign wlane    = store_data(wdata_q, funct3_q);

    // ------------------------------------------------------------------
    // Request capture (data only, no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= bus.we;
            addr_q   <= bus.addr[AW+1:0];
            wdata_q  <= bus.wdata;
            funct3_q <= bus.funct3;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered ready/err/rdata
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (bus.req) begin
                        if (!legal) begin
                            // Error response is visible in the very next cycle.
                            state   <= ERR;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= ACCESS;
                end
                ACCESS: begin
                    state   <= RESP;
                    ready_q <= 1'b1;
                    err_q   <= 1'b0;
                    if (!we_q)
                        rdata_q <= load_extend(mem[word_idx], byte_off, funct3_q);
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
                ERR: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory write port; contents survive reset, but reset in the ACCESS
    // cycle suppresses the write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && (state == ACCESS) && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i])
                    mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder: a WAIT_CYCLES=2 instance exercises
//   stores, loads, lane selection, illegal requests and reset aborts; a
//   WAIT_CYCLES=0 instance checks minimum latency and back-to-back rate.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder_if bus0 ();

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        bus.req    = r;
        bus.we     = w;
        bus.addr   = a;
        bus.wdata  = d;
        bus.funct3 = f;
    endtask

    // Issue one request on the WAIT_CYCLES=2 instance. lat counts edges from
    // the accept edge (accept edge = 1) to the first cycle showing ready;
    // lat=0 means no ready within the budget. Returns with the DUT in IDLE.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, output int lat, output logic e,
                          output logic [31:0] rd);
        drive(1'b1, w, a, d, f);
        lat = 0;
        e   = 1'b0;
        rd  = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.req = 1'b0;
            if (bus.ready) begin
                lat = k;
                e   = bus.err;
                rd  = bus.rdata;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rd);
        int          lat;
        logic        e;
        logic [31:0] rd;
        do_req(w, a, d, f, lat, e, rd);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, {31'h0, e}, {31'h0, exp_err});
        check({tag, " rdata"}, rd, exp_rd);
    endtask

    // Count ready pulses on the W=2 instance over n cycles.
    task automatic count_ready(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (bus.ready) pulses++;
        end
    endtask

    initial begin
        int pulses;
        logic exp_rdy;

        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'h0;
        bus0.wdata = 32'h0; bus0.funct3 = 3'b010;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("reset ready", {31'h0, bus.ready}, 32'h0);
        check("reset err",   {31'h0, bus.err},   32'h0);
        check("reset rdata", bus.rdata,          32'h0);
        check("reset ready w0", {31'h0, bus0.ready}, 32'h0);

        // Word store/load, latency WAIT_CYCLES+2
        xfer("sw 10",  1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 4, 1'b0, 32'h0);
        xfer("lw 10",  1'b0, 32'h10, 32'h0,        3'b010, 4, 1'b0, 32'hDEADBEEF);

        // Byte store and byte loads
        xfer("sb 13",  1'b1, 32'h13, 32'h000000AB, 3'b000, 4, 1'b0, 32'hDEADBEEF);
        xfer("lw 10b", 1'b0, 32'h10, 32'h0,        3'b010, 4, 1'b0, 32'hABADBEEF);
        xfer("lb 13",  1'b0, 32'h13, 32'h0,        3'b000, 4, 1'b0, 32'hFFFFFFAB);
        xfer("lbu 13", 1'b0, 32'h13, 32'h0,        3'b100, 4, 1'b0, 32'h000000AB);

        // Half store and half loads
        xfer("sh 12",  1'b1, 32'h12, 32'h00008001, 3'b001, 4, 1'b0, 32'h000000AB);
        xfer("lh 12",  1'b0, 32'h12, 32'h0,        3'b001, 4, 1'b0, 32'hFFFF8001);
        xfer("lhu 12", 1'b0, 32'h12, 32'h0,        3'b101, 4, 1'b0, 32'h00008001);
        xfer("lw 10c", 1'b0, 32'h10, 32'h0,        3'b010, 4, 1'b0, 32'h8001BEEF);
        xfer("lb 10",  1'b0, 32'h10, 32'h0,        3'b000, 4, 1'b0, 32'hFFFFFFEF);
        xfer("lh 10",  1'b0, 32'h10, 32'h0,        3'b001, 4, 1'b0, 32'hFFFFBEEF);
        xfer("lbu 11", 1'b0, 32'h11, 32'h0,        3'b100, 4, 1'b0, 32'h000000BE);

        // Illegal requests: error one cycle after accept, rdata cleared
        xfer("ill lw 11",   1'b0, 32'h11,   32'h0,        3'b010, 1, 1'b1, 32'h0);
        xfer("lbu 11 again", 1'b0, 32'h11,  32'h0,        3'b100, 4, 1'b0, 32'h000000BE);
        xfer("ill sh 13",   1'b1, 32'h13,   32'h0000FFFF, 3'b001, 1, 1'b1, 32'h0);
        xfer("ill ld f011", 1'b0, 32'h10,   32'h0,        3'b011, 1, 1'b1, 32'h0);
        xfer("ill sw top",  1'b1, 32'h1000, 32'h12345678, 3'b010, 1, 1'b1, 32'h0);
        xfer("ill st f100", 1'b1, 32'h10,   32'h000000FF, 3'b100, 1, 1'b1, 32'h0);
        xfer("lw 10 after", 1'b0, 32'h10,   32'h0,        3'b010, 4, 1'b0, 32'h8001BEEF);

        // Last word in range is legal
        xfer("sw ffc", 1'b1, 32'hFFC, 32'h5A5A0001, 3'b010, 4, 1'b0, 32'h8001BEEF);
        xfer("lw ffc", 1'b0, 32'hFFC, 32'h0,        3'b010, 4, 1'b0, 32'h5A5A0001);

        // Inputs toggled during WAIT/ACCESS are ignored
        drive(1'b1, 1'b1, 32'h24, 32'h11223344, 3'b010);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b010);
        check("tog wait1 ready", {31'h0, bus.ready}, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b010);
        check("tog wait2 ready", {31'h0, bus.ready}, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
        check("tog access ready", {31'h0, bus.ready}, 32'h0);
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("tog resp ready", {31'h0, bus.ready}, 32'h1);
        check("tog resp err",   {31'h0, bus.err},   32'h0);
        check("tog resp rdata", bus.rdata,          32'h5A5A0001);
        count_ready(6, pulses);
        check("tog no extra ready", 32'(pulses), 32'h0);
        xfer("lw 24", 1'b0, 32'h24, 32'h0, 3'b010, 4, 1'b0, 32'h11223344);
        xfer("lw 10 tog", 1'b0, 32'h10, 32'h0, 3'b010, 4, 1'b0, 32'h8001BEEF);

        // Reset during WAIT aborts the store
        xfer("sw 20", 1'b1, 32'h20, 32'h0BADF00D, 3'b010, 4, 1'b0, 32'h8001BEEF);
        drive(1'b1, 1'b1, 32'h20, 32'h12345678, 3'b010);
        @(posedge clk); #1;
        bus.req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst wait ready", {31'h0, bus.ready}, 32'h0);
        check("rst wait rdata", bus.rdata, 32'h0);
        count_ready(6, pulses);
        check("rst wait no ready", 32'(pulses), 32'h0);
        xfer("lw 20 a", 1'b0, 32'h20, 32'h0, 3'b010, 4, 1'b0, 32'h0BADF00D);

        // Reset coinciding with ACCESS suppresses the write; accept right after
        drive(1'b1, 1'b1, 32'h20, 32'h12345678, 3'b010);
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst acc ready", {31'h0, bus.ready}, 32'h0);
        xfer("lw 20 b", 1'b0, 32'h20, 32'h0, 3'b010, 4, 1'b0, 32'h0BADF00D);

        // WAIT_CYCLES=0 instance: store then continuously held load
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h0;
        bus0.wdata = 32'hCAFEF00D; bus0.funct3 = 3'b010;
        @(posedge clk); #1;
        bus0.req = 1'b0;
        check("w0 sw access ready", {31'h0, bus0.ready}, 32'h0);
        @(posedge clk); #1;
        check("w0 sw ready", {31'h0, bus0.ready}, 32'h1);
        @(posedge clk); #1;
        bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h0;
        bus0.wdata = 32'h0; bus0.funct3 = 3'b010;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            exp_rdy = ((k % 3) == 2);
            check($sformatf("w0 held ready k%0d", k), {31'h0, bus0.ready}, {31'h0, exp_rdy});
            if (exp_rdy)
                check($sformatf("w0 held rdata k%0d", k), bus0.rdata, 32'hCAFEF00D);
        end
        bus0.req = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the unified instruction/data memory.
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait cycles inserted before each access (0 allowed).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  1  access request from the multicycle core; sampled only in IDLE.
REQ-007 we  input  1  1 = store, 0 = load.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 funct3  input  3  RV32I size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle error flag, coincident with ready.
REQ-013 rdata  output  32  registered load result, valid while ready=1.

Function
REQ-014 States SHALL be IDLE, WAIT, ACCESS, RESP, ERR.
REQ-015 IDLE: req=1 captures we, addr, wdata, funct3 into internal registers; req=0 stays IDLE.
REQ-016 On capture, request is illegal if funct3 is not legal for the direction (loads: 000,001,010,100,101; stores: 000,001,010), or misaligned (half: addr[0]=1; word: addr[1:0]!=0), or addr[31:2] >= DEPTH_WORDS.
REQ-017 Illegal request: IDLE -> ERR; ERR drives ready=1, err=1, rdata=0 for one cycle, then IDLE; memory untouched.
REQ-018 Legal request: IDLE -> WAIT with counter=WAIT_CYCLES, or IDLE -> ACCESS when WAIT_CYCLES=0.
REQ-019 WAIT: counter decrements each cycle; exactly WAIT_CYCLES cycles spent in WAIT, then ACCESS.
REQ-020 ACCESS (one cycle): store writes only the addressed byte lanes, little-endian (sb lane addr[1:0], sh lanes addr[1]*2..+1, sw all four); load registers the extended result into rdata.
REQ-021 Load extension: lb/lh sign-extend, lbu/lhu zero-extend, lw unmodified, selected lane per addr[1:0].
REQ-022 ACCESS -> RESP; RESP drives ready=1, err=0 for one cycle, then IDLE.
REQ-023 Legal-request latency: req accepted at cycle N -> ready at cycle N+WAIT_CYCLES+2; illegal -> ready at N+1.
REQ-024 req and inputs SHALL be ignored outside IDLE; req held high through RESP is re-accepted in the following IDLE cycle (back-to-back requests every WAIT_CYCLES+3 cycles).
REQ-025 ready and err SHALL be 0 in IDLE, WAIT, ACCESS; rdata SHALL hold its last value except cleared to 0 in ERR.
REQ-026 Stores SHALL leave rdata unchanged.

Reset
REQ-027 reset=1 forces state IDLE, ready=0, err=0, rdata=0, counter=0 at the next edge; memory contents are not reset.
REQ-028 reset has priority over all transitions; a store whose ACCESS cycle coincides with reset=1 SHALL NOT write memory.
REQ-029 Reset mid-operation aborts the request with no ready pulse; first accept is possible in the cycle after reset deasserts.

Verification
REQ-030 WAIT_CYCLES=2: sw 0xDEADBEEF @0x10 accepted cycle N -> ready at N+4, err=0; lw @0x10 -> rdata=0xDEADBEEF with ready at accept+4.
REQ-031 sb wdata=0x000000AB @0x13 over 0xDEADBEEF -> lw @0x10 = 0xABADBEEF; lb @0x13 = 0xFFFFFFAB; lbu @0x13 = 0x000000AB.
REQ-032 sh 0x8001 @0x12 -> lh @0x12 = 0xFFFF8001; lhu @0x12 = 0x00008001; lw @0x10 = 0x8001BEEF.
REQ-033 lw @0x11, sh @0x13, funct3=011 load, sw @ DEPTH_WORDS*4 -> each ready=1, err=1 at accept+1, rdata=0; subsequent lw @0x10 returns unchanged data.
REQ-034 sw 0x12345678 @0x20 then reset pulsed during WAIT -> no ready pulse; lw @0x20 after reset returns prior contents; req toggled during WAIT/ACCESS is ignored.
REQ-035 WAIT_CYCLES=0 instance: lw accepted at N -> ready at N+2; req held high continuously yields ready every 3 cycles.
